// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the reusable pipeline stage register:
// ctrl stall bit indices, bubble constant and per-stage payload layouts.
package pipe_stage_reg_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam int ID_EX_W = 86;
  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = '0;

  localparam int ID_EX_ALUOP_HI  = 85;
  localparam int ID_EX_ALUOP_LO  = 78;
  localparam int ID_EX_ALUSEL_HI = 77;
  localparam int ID_EX_ALUSEL_LO = 75;
  localparam int ID_EX_WD_HI     = 74;
  localparam int ID_EX_WD_LO     = 70;
  localparam int ID_EX_WREG      = 69;
  localparam int ID_EX_REG1_HI   = 68;
  localparam int ID_EX_REG1_LO   = 37;
  localparam int ID_EX_REG2_HI   = 36;
  localparam int ID_EX_REG2_LO   = 5;
  localparam int ID_EX_SPARE_HI  = 4;
  localparam int ID_EX_SPARE_LO  = 0;

  // Field order matches the offsets above, MSB first.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  spare;
  } id_ex_t;

  function automatic logic [ID_EX_W-1:0] id_ex_pack(input id_ex_t f);
    return f;
  endfunction

  function automatic id_ex_t id_ex_unpack(input logic [ID_EX_W-1:0] v);
    return id_ex_t'(v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_stall_decode.sv
// Decodes the ctrl stall vector into one-hot bubble / hold / advance
// for the stage whose upstream stall bit is STAGE.
module pipe_stage_reg_stall_decode #(
  parameter int CTRL_W = 6,
  parameter int STAGE  = 3
) (
  input  logic [CTRL_W-1:0] ctrl,
  output logic              bubble,
  output logic              hold,
  output logic              advance
);

  logic up;
  logic dn;
  logic unused_ctrl;

  assign up = ctrl[STAGE];
  assign dn = ctrl[STAGE+1];
  assign unused_ctrl = ^ctrl;

  // up=0,dn=1 is not a legal encoding; it falls into advance.
  always_comb begin
    bubble  = 1'b0;
    hold    = 1'b0;
    advance = 1'b0;
    unique case (1'b1)
      (up && !dn): bubble  = 1'b1;
      (up && dn):  hold    = 1'b1;
      default:     advance = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Stall-aware pipeline register: valid bit, flush priority,
// hold/bubble decoding and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W = 86,
  parameter int                CTRL_W = 6,
  parameter int                STAGE  = 3,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  generate
    if (STAGE < 0 || STAGE > CTRL_W - 2) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE out of range");
    end
  endgenerate

  logic bubble;
  logic hold;
  logic advance;

  pipe_stage_reg_stall_decode #(
    .CTRL_W (CTRL_W),
    .STAGE  (STAGE)
  ) u_dec (
    .ctrl    (ctrl_signal),
    .bubble  (bubble),
    .hold    (hold),
    .advance (advance)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
      out_hold  <= 1'b0;
    end else if (flush || bubble) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
      out_hold  <= 1'b0;
    end else if (hold) begin
      out_hold  <= 1'b1;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : BUBBLE;
      out_hold  <= 1'b0;
    end
  end

  // Flush cycles are not stalls; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (!flush && (bubble || hold)
                 && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// A second instance with CNT_W=4 covers counter saturation.
module tb_pipe_stage_reg;

  localparam int DW = 86;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] ctrl_signal;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          cnt_clr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_hold;
  logic [15:0]   stall_cnt;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_hold;
  logic [3:0]    s_cnt;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_signal (ctrl_signal),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .cnt_clr     (cnt_clr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_hold    (out_hold),
    .stall_cnt   (stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .ctrl_signal (ctrl_signal),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .cnt_clr     (cnt_clr),
    .out_valid   (s_valid),
    .out_data    (s_data),
    .out_hold    (s_hold),
    .stall_cnt   (s_cnt)
  );

  always @(posedge clk) begin
    if (!rst)
      assert (!(!ctrl_signal[3] && ctrl_signal[4]))
        else $error("illegal ctrl encoding %b", ctrl_signal);
  end

  localparam logic [CW-1:0] C_ADV  = 6'b000000;
  localparam logic [CW-1:0] C_HOLD = 6'b011111;
  localparam logic [CW-1:0] C_BUB  = 6'b001111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    ctrl_signal = C_ADV; in_valid = 1'b1; in_data = '1;
    step(); step();
    asserts++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    asserts++;
    if (out_data !== '0) begin
      fails++; $display("FAIL reset_data: got %h want 0", out_data);
    end
    asserts++;
    if (stall_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    asserts++;
    if (out_hold !== 1'b0) begin
      fails++; $display("FAIL reset_hold: got %b want 0", out_hold);
    end
  endtask

  task automatic test_advance();
    rst = 1'b0; ctrl_signal = C_ADV;
    in_valid = 1'b1; in_data = 86'hA5;
    step();
    asserts++;
    if (out_data !== 86'hA5 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL adv_load: got %h/%b want a5/1", out_data, out_valid);
    end
    in_valid = 1'b0;
    step();
    asserts++;
    if (out_data !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL adv_invalid: got %h/%b want 0/0", out_data, out_valid);
    end
    asserts++;
    if (stall_cnt !== 16'd0) begin
      fails++; $display("FAIL adv_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_hold();
    ctrl_signal = C_ADV; in_valid = 1'b1; in_data = 86'h1234;
    step();
    ctrl_signal = C_HOLD; in_data = 86'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (out_data !== 86'h1234 || out_valid !== 1'b1
          || out_hold !== 1'b1) begin
        fails++;
        $display("FAIL hold_%0d: got %h/%b/%b want 1234/1/1",
                 i, out_data, out_valid, out_hold);
      end
    end
    asserts++;
    if (stall_cnt !== 16'd3) begin
      fails++; $display("FAIL hold_cnt: got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_bubble();
    ctrl_signal = C_BUB; in_valid = 1'b1; in_data = 86'hFFFF;
    step();
    asserts++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_hold !== 1'b0) begin
      fails++;
      $display("FAIL bubble: got %h/%b/%b want 0/0/0",
               out_data, out_valid, out_hold);
    end
    asserts++;
    if (stall_cnt !== 16'd4) begin
      fails++; $display("FAIL bubble_cnt: got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_flush();
    ctrl_signal = C_ADV; in_valid = 1'b1; in_data = 86'h55;
    step();
    ctrl_signal = C_HOLD;
    step();
    asserts++;
    if (out_data !== 86'h55 || stall_cnt !== 16'd5) begin
      fails++;
      $display("FAIL flush_pre: got %h/%0d want 55/5", out_data, stall_cnt);
    end
    flush = 1'b1;
    step();
    asserts++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_hold !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold: got %h/%b/%b want 0/0/0",
               out_data, out_valid, out_hold);
    end
    asserts++;
    if (stall_cnt !== 16'd5) begin
      fails++; $display("FAIL flush_cnt: got %0d want 5", stall_cnt);
    end
    rst = 1'b1;
    step();
    asserts++;
    if (stall_cnt !== 16'd0 || out_valid !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL rst_flush: got %0d/%b/%h want 0/0/0",
               stall_cnt, out_valid, out_data);
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    ctrl_signal = C_ADV; in_valid = 1'b1; in_data = 86'h77;
    step();
    ctrl_signal = C_HOLD;
    step();
    rst = 1'b1;
    step();
    asserts++;
    if (out_data !== '0 || out_hold !== 1'b0 || out_valid !== 1'b0
        || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_hold: got %h/%b/%b/%0d want 0/0/0/0",
               out_data, out_hold, out_valid, stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    ctrl_signal = C_ADV; in_valid = 1'b1; in_data = 86'h9;
    step();
    ctrl_signal = C_HOLD;
    for (int i = 0; i < 20; i++) step();
    asserts++;
    if (s_cnt !== 4'd15) begin
      fails++; $display("FAIL sat_cnt4: got %0d want 15", s_cnt);
    end
    asserts++;
    if (stall_cnt !== 16'd20) begin
      fails++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt);
    end
    cnt_clr = 1'b1;
    step();
    asserts++;
    if (s_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clr_cnt: got %0d/%0d want 0/0", s_cnt, stall_cnt);
    end
    cnt_clr = 1'b0;
    step();
    asserts++;
    if (s_cnt !== 4'd1 || s_data !== 86'h9) begin
      fails++;
      $display("FAIL clr_resume: got %0d/%h want 1/9", s_cnt, s_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vec [3];
    vec[0] = 86'h1; vec[1] = {86{1'b1}}; vec[2] = 86'h2A_0000_0000;
    ctrl_signal = C_ADV; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      step();
      asserts++;
      if (out_data !== vec[i] || out_valid !== 1'b1
          || out_hold !== 1'b0) begin
        fails++;
        $display("FAIL b2b_%0d: got %h/%b/%b want %h/1/0",
                 i, out_data, out_valid, out_hold, vec[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_hold();
    test_bubble();
    test_flush();
    test_reset_mid_hold();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
